// File: rtl/ivi_pulse_gen_if.sv
// Host control and generated pattern lines of the interval-meter test-pattern generator.
`timescale 1ns/1ps
interface ivi_pulse_gen_if;
  logic       access;
  logic       start;
  logic [2:0] regime;
  logic [3:0] mic_100;
  logic [3:0] mic_010;
  logic [3:0] mic_001;
  logic [3:0] n_100;
  logic [3:0] n_010;
  logic [3:0] n_001;
  logic       sync_pos;
  logic       sync_neg;
  logic       sig_1;
  logic       sig_2;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output access, start, regime,
    output mic_100, mic_010, mic_001, n_100, n_010, n_001,
    input  sync_pos, sync_neg, sig_1, sig_2, busy, done, err
  );

  modport slave (
    input  access, start, regime,
    input  mic_100, mic_010, mic_001, n_100, n_010, n_001,
    output sync_pos, sync_neg, sig_1, sig_2, busy, done, err
  );
endinterface

// File: rtl/ivi_pulse_gen.sv
// Sync + duration/period/delay pattern generator; interval held as BCD digits at 5 ns per count.
`timescale 1ns/1ps
module ivi_pulse_gen #(
  parameter int unsigned SYNC_W   = 4,
  parameter int unsigned LEAD_GAP = 8,
  parameter int unsigned PW       = 20
) (
  input  logic           clk_200MHz,
  input  logic           reset,
  ivi_pulse_gen_if.slave pg
);

  localparam logic [2:0] REG_DUR = 3'b011;
  localparam logic [2:0] REG_PER = 3'b101;
  localparam logic [2:0] REG_DLY = 3'b110;

  localparam int unsigned MAX_SG  = (SYNC_W > LEAD_GAP) ? SYNC_W : LEAD_GAP;
  localparam int unsigned MAX_ALL = (MAX_SG > PW) ? MAX_SG : PW;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SYNC,
    GAP,
    RUN,
    TAIL,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic            start_q;
  logic            trigger;
  logic            invalid;
  logic            digit_bad;
  logic            bcd_zero;
  logic            bcd_step;
  logic            borrow;
  logic [2:0]      regime_q;
  logic [5:0][3:0] dig;
  logic [5:0][3:0] dig_dec;
  logic [19:0]     ns_val;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt2;

  logic sync_pos_q, sync_neg_q, sig_1_q, sig_2_q, busy_q, done_q, err_q;
  logic sync_pos_n, sync_neg_n, sig_1_n, sig_2_n, busy_n, done_n, err_n;

  assign trigger = (state == IDLE) && pg.access && pg.start && !start_q;

  // start history is kept across access drops so a start held high never looks like a new edge
  always_ff @(posedge clk_200MHz) begin
    if (!reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= pg.start;
    end
  end

  assign bcd_zero = (dig == '0);
  assign bcd_step = ((state == GAP) && (cnt == '0)) ||
                    (((state == RUN) || (state == TAIL)) && !bcd_zero);

  // n_001 toggles 5/0; every higher digit rolls 0 -> 9 while the borrow ripples upward
  always_comb begin
    dig_dec = dig;
    borrow  = 1'b0;
    if (dig[0] == 4'd0) begin
      dig_dec[0] = 4'd5;
      borrow     = 1'b1;
    end else begin
      dig_dec[0] = 4'd0;
    end
    for (int unsigned i = 1; i < 6; i++) begin
      if (borrow) begin
        if (dig[i] == 4'd0) begin
          dig_dec[i] = 4'd9;
        end else begin
          dig_dec[i] = dig[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  // The binary value only feeds the period-length check; all timing runs on the BCD counter.
  always_comb begin
    digit_bad = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (dig[i] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
    ns_val = 20'(dig[5]) * 20'd100000 + 20'(dig[4]) * 20'd10000 +
             20'(dig[3]) * 20'd1000   + 20'(dig[2]) * 20'd100   +
             20'(dig[1]) * 20'd10     + 20'(dig[0]);
    invalid = digit_bad ||
              ((dig[0] != 4'd0) && (dig[0] != 4'd5)) ||
              bcd_zero ||
              !(regime_q inside {REG_DUR, REG_PER, REG_DLY}) ||
              ((regime_q == REG_PER) && (ns_val <= 20'(PW * 5)));
  end

  always_ff @(posedge clk_200MHz) begin
    if (!reset) begin
      dig      <= '0;
      regime_q <= '0;
      cnt      <= '0;
      cnt2     <= '0;
    end else begin
      if (trigger) begin
        dig      <= {pg.mic_100, pg.mic_010, pg.mic_001, pg.n_100, pg.n_010, pg.n_001};
        regime_q <= pg.regime;
      end else if (bcd_step) begin
        dig <= dig_dec;
      end

      if (state == CHECK) begin
        cnt <= CW'(SYNC_W - 1);
      end else if ((state == SYNC) && (cnt == '0)) begin
        cnt <= CW'(LEAD_GAP - 1);
      end else if ((state == GAP) && (cnt == '0)) begin
        cnt <= CW'(PW - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if ((state == RUN) && bcd_zero) begin
        cnt2 <= CW'(PW - 1);
      end else if (cnt2 != '0) begin
        cnt2 <= cnt2 - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_200MHz) begin
    if (!reset || !pg.access) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (trigger) next_state = CHECK;
      CHECK:   next_state = invalid ? IDLE : SYNC;
      SYNC:    if (cnt == '0) next_state = GAP;
      GAP:     if (cnt == '0) next_state = RUN;
      RUN:     if (bcd_zero) next_state = (regime_q == REG_DUR) ? DONE : TAIL;
      TAIL:    if (cnt2 == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are the registered image of the state being entered, so they line up with it.
  always_comb begin
    sync_pos_n = 1'b0;
    sync_neg_n = 1'b1;
    sig_1_n    = 1'b0;
    sig_2_n    = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    unique case (next_state)
      IDLE:  err_n = (state == CHECK);
      CHECK: ;
      SYNC: begin
        busy_n     = 1'b1;
        sync_pos_n = 1'b1;
        sync_neg_n = 1'b0;
      end
      GAP:   busy_n = 1'b1;
      RUN: begin
        busy_n = 1'b1;
        if ((state == GAP) || (regime_q == REG_DUR)) begin
          sig_1_n = 1'b1;
        end else begin
          sig_1_n = sig_1_q && (cnt != '0);
        end
      end
      TAIL: begin
        busy_n = 1'b1;
        if (regime_q == REG_PER) begin
          sig_1_n = 1'b1;
        end else begin
          sig_1_n = sig_1_q && (cnt != '0);
          sig_2_n = 1'b1;
        end
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_200MHz) begin
    if (!reset || !pg.access) begin
      sync_pos_q <= 1'b0;
      sync_neg_q <= 1'b1;
      sig_1_q    <= 1'b0;
      sig_2_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_pos_q <= sync_pos_n;
      sync_neg_q <= sync_neg_n;
      sig_1_q    <= sig_1_n;
      sig_2_q    <= sig_2_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  assign pg.sync_pos = sync_pos_q;
  assign pg.sync_neg = sync_neg_q;
  assign pg.sig_1    = sig_1_q;
  assign pg.sig_2    = sig_2_q;
  assign pg.busy     = busy_q;
  assign pg.done     = done_q;
  assign pg.err      = err_q;

endmodule

// File: tb/tb_ivi_pulse_gen.sv
// Randomized self-checking bench for ivi_pulse_gen against a waveform model built from interval arithmetic.
`timescale 1ns/1ps
module tb_ivi_pulse_gen;
  localparam int SYNC_W   = 4;
  localparam int LEAD_GAP = 8;
  localparam int PW       = 20;
  localparam int T0       = 1 + SYNC_W + LEAD_GAP;
  localparam int MAXT     = 20200;
  localparam logic [6:0] IDLE_V = 7'b0100000;

  logic clk_200MHz = 1'b0;
  logic reset      = 1'b0;
  int   checks     = 0;
  int   errors     = 0;
  logic [6:0] trace [0:MAXT];

  ivi_pulse_gen_if pg_if ();

  ivi_pulse_gen #(
    .SYNC_W  (SYNC_W),
    .LEAD_GAP(LEAD_GAP),
    .PW      (PW)
  ) dut (
    .clk_200MHz(clk_200MHz),
    .reset     (reset),
    .pg        (pg_if)
  );

  always #2.5 clk_200MHz = ~clk_200MHz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // {sync_pos, sync_neg, sig_1, sig_2, busy, done, err}
  function automatic logic [6:0] obs();
    return {pg_if.sync_pos, pg_if.sync_neg, pg_if.sig_1, pg_if.sig_2,
            pg_if.busy, pg_if.done, pg_if.err};
  endfunction

  // Interval in clocks, or -1 when the request must be rejected.
  function automatic int model_n(input logic [2:0] rg, input logic [23:0] digs);
    int d;
    int ns;
    ns = 0;
    for (int i = 5; i >= 0; i--) begin
      d = int'(digs[i*4 +: 4]);
      if (d > 9) return -1;
      ns = ns * 10 + d;
    end
    if (ns == 0 || (ns % 5) != 0) return -1;
    if (!(rg == 3'b011 || rg == 3'b101 || rg == 3'b110)) return -1;
    if (rg == 3'b101 && (ns / 5) <= PW) return -1;
    return ns / 5;
  endfunction

  // Expected outputs k clocks after the edge that sees the start rise.
  function automatic logic [6:0] exp_vec(input logic [2:0] rg, input logic [23:0] digs, input int k);
    int n;
    int tend;
    logic sp, s1, s2, b, dn;
    n = model_n(rg, digs);
    if (n < 0) return {1'b0, 1'b1, 4'b0000, (k == 1)};
    tend = (rg == 3'b011) ? T0 + n : T0 + n + PW;
    sp = (k >= 1) && (k <= SYNC_W);
    b  = (k >= 1) && (k < tend);
    dn = (k == tend);
    s1 = 1'b0;
    s2 = 1'b0;
    if (rg == 3'b011) s1 = (k >= T0) && (k < T0 + n);
    if (rg == 3'b101) s1 = ((k >= T0) && (k < T0 + PW)) || ((k >= T0 + n) && (k < T0 + n + PW));
    if (rg == 3'b110) begin
      s1 = (k >= T0) && (k < T0 + PW);
      s2 = (k >= T0 + n) && (k < T0 + n + PW);
    end
    return {sp, !sp, s1, s2, b, dn, 1'b0};
  endfunction

  function automatic int run_len(input logic [2:0] rg, input logic [23:0] digs);
    int n;
    n = model_n(rg, digs);
    if (n < 0) return 4;
    return T0 + n + ((rg == 3'b011) ? 0 : PW) + 4;
  endfunction

  // Drives one start edge and records outputs for ncyc clocks; no checking here.
  task automatic capture(input logic [2:0] rg, input logic [23:0] digs, input int ncyc,
                         input int repulse_k, input bit hold, input int abort_k);
    @(negedge clk_200MHz);
    pg_if.start = 1'b0;
    @(negedge clk_200MHz);
    pg_if.regime = rg;
    {pg_if.mic_100, pg_if.mic_010, pg_if.mic_001, pg_if.n_100, pg_if.n_010, pg_if.n_001} = digs;
    pg_if.start = 1'b1;
    @(posedge clk_200MHz);
    #1 trace[0] = obs();
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk_200MHz);
      if (k == 1 && !hold) pg_if.start = 1'b0;
      if (k == repulse_k) pg_if.start = 1'b1;
      if (k == repulse_k + 2) pg_if.start = 1'b0;
      if (k == abort_k) pg_if.access = 1'b0;
      if (k == abort_k + 2) pg_if.access = 1'b1;
      @(posedge clk_200MHz);
      #1 trace[k] = obs();
    end
    @(negedge clk_200MHz);
    pg_if.start  = 1'b0;
    pg_if.access = 1'b1;
  endtask

  task automatic test_reset();
    pg_if.access = 1'b1;
    pg_if.start  = 1'b0;
    pg_if.regime = 3'b011;
    {pg_if.mic_100, pg_if.mic_010, pg_if.mic_001, pg_if.n_100, pg_if.n_010, pg_if.n_001} = 24'h001000;
    reset = 1'b0;
    repeat (3) @(posedge clk_200MHz);
    #1;
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs(), IDLE_V);
    end
    @(negedge clk_200MHz);
    reset = 1'b1;
    // reset asserted on the same clock as a start rise
    @(negedge clk_200MHz);
    reset = 1'b0;
    pg_if.start = 1'b1;
    @(negedge clk_200MHz);
    reset = 1'b1;
    pg_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_200MHz);
      #1;
      checks++;
      if (obs() !== IDLE_V) begin
        errors++;
        $display("FAIL reset_vs_trigger cyc=%0d got=%b exp=%b", i, obs(), IDLE_V);
        break;
      end
    end
    // access low on the same clock as a start rise; start then held high
    @(negedge clk_200MHz);
    pg_if.access = 1'b0;
    pg_if.start  = 1'b1;
    @(negedge clk_200MHz);
    pg_if.access = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_200MHz);
      #1;
      checks++;
      if (obs() !== IDLE_V) begin
        errors++;
        $display("FAIL access_vs_trigger cyc=%0d got=%b exp=%b", i, obs(), IDLE_V);
        break;
      end
    end
    @(negedge clk_200MHz);
    pg_if.start = 1'b0;
  endtask

  task automatic test_duration();
    logic [23:0] digs;
    int len, hi, dn;
    digs = 24'h001000;
    len  = run_len(3'b011, digs);
    capture(3'b011, digs, len, -1, 1'b0, -1);
    hi = 0;
    dn = 0;
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (trace[k] !== exp_vec(3'b011, digs, k)) begin
        errors++;
        $display("FAIL duration_trace k=%0d got=%b exp=%b", k, trace[k], exp_vec(3'b011, digs, k));
        break;
      end
    end
    for (int k = 0; k <= len; k++) begin
      if (trace[k][4]) hi++;
      if (trace[k][1]) dn++;
    end
    checks++;
    if (hi !== 200) begin
      errors++;
      $display("FAIL duration_width got=%0d exp=200", hi);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL duration_done_count got=%0d exp=1", dn);
    end
  endtask

  task automatic test_period();
    logic [23:0] digs;
    int len, r0, r1, hi;
    digs = 24'h002505;
    len  = run_len(3'b101, digs);
    capture(3'b101, digs, len, -1, 1'b0, -1);
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (trace[k] !== exp_vec(3'b101, digs, k)) begin
        errors++;
        $display("FAIL period_trace k=%0d got=%b exp=%b", k, trace[k], exp_vec(3'b101, digs, k));
        break;
      end
    end
    r0 = -1;
    r1 = -1;
    hi = 0;
    for (int k = 1; k <= len; k++) begin
      if (trace[k][4]) hi++;
      if (trace[k][4] && !trace[k-1][4]) begin
        if (r0 < 0) r0 = k;
        else if (r1 < 0) r1 = k;
      end
    end
    checks++;
    if (r1 - r0 !== 501) begin
      errors++;
      $display("FAIL period_spacing got=%0d exp=501", r1 - r0);
    end
    checks++;
    if (hi !== 40) begin
      errors++;
      $display("FAIL period_high_total got=%0d exp=40", hi);
    end
  endtask

  task automatic test_delay();
    logic [23:0] digs;
    int len, r1, r2, ov;
    digs = 24'h000035;
    len  = run_len(3'b110, digs);
    capture(3'b110, digs, len, -1, 1'b0, -1);
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (trace[k] !== exp_vec(3'b110, digs, k)) begin
        errors++;
        $display("FAIL delay_trace k=%0d got=%b exp=%b", k, trace[k], exp_vec(3'b110, digs, k));
        break;
      end
    end
    r1 = -1;
    r2 = -1;
    ov = 0;
    for (int k = 1; k <= len; k++) begin
      if (r1 < 0 && trace[k][4] && !trace[k-1][4]) r1 = k;
      if (r2 < 0 && trace[k][3] && !trace[k-1][3]) r2 = k;
      if (trace[k][4] && trace[k][3]) ov++;
    end
    checks++;
    if (r2 - r1 !== 7) begin
      errors++;
      $display("FAIL delay_offset got=%0d exp=7", r2 - r1);
    end
    checks++;
    if (ov !== 13) begin
      errors++;
      $display("FAIL delay_overlap got=%0d exp=13", ov);
    end
  endtask

  task automatic test_errors();
    logic [2:0]  rgs  [4] = '{3'b011, 3'b000, 3'b011, 3'b101};
    logic [23:0] dgs  [4] = '{24'h000003, 24'h001000, 24'h000000, 24'h000050};
    int len, ec, act;
    for (int c = 0; c < 4; c++) begin
      len = 12;
      capture(rgs[c], dgs[c], len, -1, 1'b0, -1);
      ec  = 0;
      act = 0;
      for (int k = 0; k <= len; k++) begin
        if (trace[k][0]) ec++;
        if (trace[k][6] || trace[k][2]) act++;
      end
      checks++;
      if (ec !== 1 || act !== 0 || trace[1][0] !== 1'b1) begin
        errors++;
        $display("FAIL error_case%0d err_pulses=%0d sync_or_busy=%0d exp err_pulses=1 sync_or_busy=0", c, ec, act);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] digs;
    int len;
    digs = 24'h001000;
    len  = run_len(3'b011, digs);
    capture(3'b011, digs, len, T0 + 40, 1'b0, -1);
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (trace[k] !== exp_vec(3'b011, digs, k)) begin
        errors++;
        $display("FAIL repulse_trace k=%0d got=%b exp=%b", k, trace[k], exp_vec(3'b011, digs, k));
        break;
      end
    end
    digs = 24'h000100;
    len  = run_len(3'b011, digs) + 12;
    capture(3'b011, digs, len, -1, 1'b1, -1);
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (trace[k] !== exp_vec(3'b011, digs, k)) begin
        errors++;
        $display("FAIL held_start_trace k=%0d got=%b exp=%b", k, trace[k], exp_vec(3'b011, digs, k));
        break;
      end
    end
  endtask

  task automatic test_abort();
    logic [23:0] digs;
    logic [6:0]  e;
    int len, ak;
    digs = 24'h001000;
    len  = run_len(3'b011, digs);
    ak   = T0 + 50;
    capture(3'b011, digs, len, -1, 1'b0, ak);
    for (int k = 0; k <= len; k++) begin
      e = (k < ak) ? exp_vec(3'b011, digs, k) : IDLE_V;
      checks++;
      if (trace[k] !== e) begin
        errors++;
        $display("FAIL abort_trace k=%0d got=%b exp=%b", k, trace[k], e);
        break;
      end
    end
    capture(3'b011, digs, len, -1, 1'b0, -1);
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (trace[k] !== exp_vec(3'b011, digs, k)) begin
        errors++;
        $display("FAIL after_abort_trace k=%0d got=%b exp=%b", k, trace[k], exp_vec(3'b011, digs, k));
        break;
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  rg;
    logic [23:0] digs;
    int len;
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 7))
        0, 1:    rg = 3'b011;
        2, 3:    rg = 3'b101;
        4, 5:    rg = 3'b110;
        default: rg = 3'($urandom_range(0, 7));
      endcase
      digs = {4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), ($urandom_range(0, 1) != 0) ? 4'd5 : 4'd0};
      if ($urandom_range(0, 7) == 0) digs[3:0] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) digs[7:4] = 4'($urandom_range(10, 15));
      len = run_len(rg, digs);
      capture(rg, digs, len, -1, 1'b0, -1);
      for (int k = 0; k <= len; k++) begin
        checks++;
        if (trace[k] !== exp_vec(rg, digs, k)) begin
          errors++;
          $display("FAIL random%0d rg=%b digs=%h k=%0d got=%b exp=%b", r, rg, digs, k, trace[k], exp_vec(rg, digs, k));
          break;
        end
      end
    end
  endtask

  task automatic test_long();
    logic [23:0] digs;
    int len, hi;
    digs = 24'h100005;
    len  = run_len(3'b011, digs);
    capture(3'b011, digs, len, -1, 1'b0, -1);
    hi = 0;
    for (int k = 0; k <= len; k++) begin
      if (trace[k][4]) hi++;
    end
    checks++;
    if (hi !== 20001) begin
      errors++;
      $display("FAIL long_width got=%0d exp=20001", hi);
    end
    checks++;
    if (trace[T0 + 20001] !== exp_vec(3'b011, digs, T0 + 20001)) begin
      errors++;
      $display("FAIL long_done got=%b exp=%b", trace[T0 + 20001], exp_vec(3'b011, digs, T0 + 20001));
    end
  endtask

  initial begin
    test_reset();
    test_duration();
    test_period();
    test_delay();
    test_errors();
    test_back_to_back();
    test_abort();
    test_random();
    test_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ivi_pulse_gen.md
Name: ivi_pulse_gen

Overview:
Test-pattern generator that drives the sync and signal lines consumed by the interval meter. Each run emits one sync pulse followed by a programmed duration, period or delay pattern on sig_1/sig_2. The interval is given as BCD digits at 5 ns resolution, in the same digit format the meter reports. Used for self-calibration loopback and bench verification of the meter.

Parameters:
SYNC_W, 4, sync pulse width in clocks (≥1)
LEAD_GAP, 8, clocks from sync fall to first sig_1 rise (≥1)
PW, 20, width in clocks of sig_1/sig_2 marker pulses in period/delay modes (≥1)

Ports:
clk_200MHz  in  1  200 MHz clock; one tick is 5 ns
reset  in  1  synchronous, active-low
access  in  1  0 = abort and hold idle; 1 = enabled
start  in  1  run request, rising-edge sensitive
regime  in  3  011 duration, 101 period, 110 delay
mic_100, mic_010, mic_001  in  4 each  µs BCD digits
n_100, n_010, n_001  in  4 each  ns BCD digits; n_001 must be 0 or 5
sync_pos  out  1  active-high sync pulse
sync_neg  out  1  active-low sync pulse, complement of sync_pos
sig_1  out  1  measured-signal line 1
sig_2  out  1  measured-signal line 2 (delay mode only)
busy  out  1  run in progress
done  out  1  one-clock pulse at run completion
err  out  1  one-clock pulse when a trigger is rejected

Behaviour:
- All outputs are registered. On reset==0: sync_pos=0, sync_neg=1, sig_1=0, sig_2=0, busy=0, done=0, err=0. The state returns to IDLE and the start edge register clears.
- access==0 has the same effect as reset, except the start edge register keeps tracking start. This holds in any state, mid-run included. Outputs return to idle levels on the next edge.
- Trigger: in IDLE with access=1, start=1 while start was 0 on the previous clock. Any start edge outside IDLE is ignored.
- Interval N = value(digits in ns) / 5 clocks. Range 1 to 199999 clocks.
- On the trigger, digits and regime are latched. The cycle after the trigger, the block does one of two things:
  - It pulses err for 1 clock and stays IDLE if any of the following holds: any digit > 9; n_001 not 0 or 5; N == 0; regime not 011/101/110; regime 101 with N ≤ PW.
  - Otherwise it enters SYNC and sets busy=1, sync_pos=1, sync_neg=0.
- The interval is counted with a cascaded BCD down-counter. n_001 alternates 5→0, borrow on 0→5, then each higher digit borrows on 0→9. The interval has elapsed when all digits reach 0. There is no binary conversion.
- States:
  - IDLE.
  - SYNC: SYNC_W clocks with sync asserted.
  - GAP: LEAD_GAP clocks with sync deasserted.
  - RUN: t0 is the first clock sig_1=1.
  - TAIL.
  - DONE: 1 clock, done=1, busy=0, then IDLE.
- Regime 011 (duration): sig_1=1 for exactly N clocks from t0. It falls at t0+N, then DONE. sig_2 stays 0.
- Regime 101 (period): rising edges on sig_1 exactly N clocks apart.
  - sig_1 high on [t0, t0+PW).
  - Low on [t0+PW, t0+N).
  - High on [t0+N, t0+N+PW), then DONE.
- Regime 110 (delay): sig_1 high on [t0, t0+PW). sig_2 high on [t0+N, t0+N+PW).
  - Overlap is allowed when N < PW.
  - DONE follows once both are low.
- A binary PW counter runs independently of the BCD down-counter.
- Reset or access drop on the same clock as a trigger: reset/abort wins, and no run starts.

Test Plan:
- Duration, mic_001=1, all others 0 (1.000 µs) -> sync_pos high 4 clocks, 8-clock gap, sig_1 high exactly 200 clocks; done pulses once; busy low afterward.
- Period, mic_001=2, n_100=5, n_001=5 (2.505 µs) -> sig_1 rising edges exactly 501 clocks apart, each pulse 20 clocks wide.
- Delay, n_010=3, n_001=5 (35 ns), PW=20 -> sig_2 rises 7 clocks after sig_1 rises; the pulses overlap; done after sig_2 falls.
- Error cases: n_001=3, regime=000, all-zero digits, or period with n_010=5 (N=10 ≤ PW) -> err pulses 1 clock; busy stays 0; no sync activity.
- Start re-pulsed during RUN -> ignored, pattern unchanged. A start held high across DONE does not retrigger until it goes low then high.
- access dropped mid-RUN of a 1 µs duration run -> next clock sig_1=0, busy=0, no done. Restoring access plus a fresh start edge gives a full correct run.
